i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- I2C target (responder) with an 8-entry byte register file; the responding end of the bus driven by the existing I2C master and its system controller.
- Registers 0-3 are written by the bus master. Registers 4-7 are read-only images of core inputs.
- Gated by a time-slot enable, so several instances can share one master under domain time multiplexing.
- Single clock. SCL and SDA are oversampled; the block drives SDA open-drain only.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on scl_i and sda_i.
- FILTER_LEN, 3, consecutive equal samples needed before a filtered SCL/SDA level changes.

Ports:
- clk  input  1  system clock
- arst_i  input  1  asynchronous reset, active low
- slot_en  input  1  1 = this target's time slot is active; 0 = bus ignored
- slave_addr  input  7  target address, static while in use
- scl_i  input  1  SCL pad input
- sda_i  input  1  SDA pad input
- sda_o  output  1  SDA drive value, tied 0
- sda_oen  output  1  SDA output enable, active low (0 = pull low, 1 = release)
- ro_reg4..ro_reg7  input  8 each  read-only register sources
- rw_reg0..rw_reg3  output  8 each  master-writable registers
- wr_stb  output  1  one-cycle pulse when a register 0-3 is written
- wr_idx  output  2  index of the last write
- busy  output  1  addressed transaction in progress

Behaviour:
Reset (arst_i = 0):
- State IDLE; sda_oen = 1; rw_reg0..3 = 8'h00; pointer = 0; wr_stb = 0; wr_idx = 0; busy = 0.
- Filtered SCL and SDA preset to 1.

Input conditioning:
- Synchronize, then filter.
- Edge and START/STOP detection use only the filtered levels.
- Latency from pad to filtered level is SYNC_STAGES + FILTER_LEN cycles.

Bus events:
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Any START, including a repeated START, enters ADDR from any state.
- STOP enters IDLE from any state.
- slot_en = 0 forces IDLE and sda_oen = 1 in the same cycle. Mid-transfer bits are discarded, rw_regs are kept, and the pointer is kept.

Bit timing:
- Data bits are sampled on filtered SCL rising edges, MSB first.
- sda_oen changes only on the cycle after a filtered SCL falling edge.

States:
- IDLE → ADDR on START.
- ADDR: shift 8 bits.
  - If bits [7:1] == slave_addr, go to ADDR_ACK and drive ACK (sda_oen = 0) for one SCL period.
  - Otherwise go to IDLE and do not ACK.
- After ADDR_ACK:
  - R/W = 0 → PTR.
  - R/W = 1 → RDATA, loading the shift register from reg[pointer].
- PTR: shift 8 bits; pointer = byte[2:0] (upper bits ignored); ACK; → WDATA.
- WDATA: shift 8 bits, then ACK.
  - If pointer ≤ 3: rw_reg[pointer] is updated and wr_stb pulses in the cycle after the 8th rising edge; wr_idx = pointer.
  - If pointer 4-7: data is dropped but still ACKed.
  - Pointer then increments and WDATA repeats.
- RDATA: drive 8 bits (sda_oen = 0 for a 0 bit, 1 for a 1 bit), then release and sample the master ACK on the 9th rising edge.
  - ACK (0): pointer increments, next byte is loaded, stay in RDATA.
  - NACK (1): go to IDLE and release.

Pointer:
- 3 bits, increments modulo 8 (7 → 0).
- Read data is captured at load time. A change to ro_reg during a byte does not corrupt that byte.

busy:
- 1 from address match until STOP, NACK, slot_en = 0, or a non-matching START.

Optional Feature:
- Macro: I2C_TARGET_RO_NACK_EN.
- Defined: a WDATA byte with pointer 4-7 is NACKed (sda_oen stays 1 in the ACK slot), the state goes to IDLE, and the pointer does not increment.
- Not defined: the byte is ACKed, dropped, and the pointer increments (behaviour above).

Test Plan:
- Write: slave_addr = 7'h10; S, 0x20, 0x01, 0xA5, 0x5A, P → all ACK; rw_reg1 = A5, rw_reg2 = 5A; two wr_stb pulses with wr_idx 1 then 2.
- Read with repeated START: ro_reg4..7 = 12,34,56,78; S, 0x20, 0x04, Sr, 0x21, read 4 bytes (ACK,ACK,ACK,NACK) → 12,34,56,78; busy = 0 after the NACK.
- Pointer wrap: write pointer 0x07, read 2 bytes → ro_reg7 then rw_reg0.
- Wrong address: S, 0x40 → no ACK; SDA released for the whole transaction; busy stays 0; no rw_reg change.
- Slot gating: drop slot_en mid-byte during a write to reg 3 → sda_oen = 1 next cycle, rw_reg3 unchanged. Re-enable and do a fresh write of 0x3C → rw_reg3 = 3C.
- Glitch and RO write: a 2-cycle SCL pulse (FILTER_LEN = 3) shifts no bit. A write to pointer 5 is ACKed without the macro and NACKed, ending in IDLE, with I2C_TARGET_RO_NACK_EN.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
//   I2C target with an 8-entry byte register file. Registers 0-3 are written
//   by the bus master; registers 4-7 read back the ro_reg4..7 core inputs.
//   SCL/SDA are synchronized and glitch-filtered before any bus decoding.
//   SDA is driven open-drain only (sda_o tied low, sda_oen active low).
//   When slot_en is low the bus is ignored and the target returns to IDLE.
//
// Optional feature macro: I2C_TARGET_RO_NACK_EN
//   Defined     : a write data byte aimed at pointer 4-7 is NACKed, the target
//                 returns to IDLE and the pointer is not incremented.
//   Not defined : such a byte is ACKed, dropped, and the pointer increments.
//
// Ports
//   clk                 system clock
//   arst_i              asynchronous reset, active low
//   slot_en             1 = time slot active, 0 = bus ignored
//   slave_addr[6:0]     7-bit target address
//   scl_i, sda_i        pad inputs
//   sda_o               SDA drive value (always 0)
//   sda_oen             SDA output enable, active low
//   ro_reg4..ro_reg7    read-only register sources
//   rw_reg0..rw_reg3    master-writable registers
//   wr_stb              one-cycle pulse on a register 0-3 write
//   wr_idx[1:0]         index of the last write
//   busy                addressed transaction in progress
module i2c_target_regfile #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       arst_i,
  input  logic       slot_en,
  input  logic [6:0] slave_addr,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  input  logic [7:0] ro_reg4,
  input  logic [7:0] ro_reg5,
  input  logic [7:0] ro_reg6,
  input  logic [7:0] ro_reg7,
  output logic [7:0] rw_reg0,
  output logic [7:0] rw_reg1,
  output logic [7:0] rw_reg2,
  output logic [7:0] rw_reg3,
  output logic       wr_stb,
  output logic [1:0] wr_idx,
  output logic       busy
);

  localparam int CW = $clog2(FILTER_LEN + 1);

`ifdef I2C_TARGET_RO_NACK_EN
  localparam logic RO_WRITE_ACK = 1'b0;
`else
  localparam logic RO_WRITE_ACK = 1'b1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_PTR   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic [CW-1:0]          scl_cnt_r, sda_cnt_r;
  logic                   scl_filt_r, sda_filt_r;
  logic                   scl_prev_r, sda_prev_r;
  logic                   scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r;
  logic [3:0] bit_cnt_r;   // 0..7 data bits, 8 = ACK slot pending, 9 = ACK clocked
  logic [7:0] shreg_r;
  logic       ack_r;
  logic       rw_r;
  logic [2:0] ptr_r;
  logic       sda_oen_r;
  logic [7:0] rw_q [4];
  logic       wr_stb_r;
  logic [1:0] wr_idx_r;
  logic       busy_r;
  logic [7:0] byte_in_s;
  logic [7:0] rd_byte_s;

  // Pad synchronizers, preset to the idle-high bus level.
  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
    end
  end

  // SCL filter: the level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      scl_filt_r <= 1'b1;
      scl_cnt_r  <= {CW{1'b0}};
    end else if (scl_sync_r[SYNC_STAGES-1] == scl_filt_r) begin
      scl_cnt_r <= {CW{1'b0}};
    end else if (scl_cnt_r == CW'(FILTER_LEN - 1)) begin
      scl_filt_r <= scl_sync_r[SYNC_STAGES-1];
      scl_cnt_r  <= {CW{1'b0}};
    end else begin
      scl_cnt_r <= scl_cnt_r + CW'(1);
    end
  end

  // SDA filter, same rule as SCL so both paths have equal latency.
  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      sda_filt_r <= 1'b1;
      sda_cnt_r  <= {CW{1'b0}};
    end else if (sda_sync_r[SYNC_STAGES-1] == sda_filt_r) begin
      sda_cnt_r <= {CW{1'b0}};
    end else if (sda_cnt_r == CW'(FILTER_LEN - 1)) begin
      sda_filt_r <= sda_sync_r[SYNC_STAGES-1];
      sda_cnt_r  <= {CW{1'b0}};
    end else begin
      sda_cnt_r <= sda_cnt_r + CW'(1);
    end
  end

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_filt_r;
      sda_prev_r <= sda_filt_r;
    end
  end

  // Bus event decode from filtered levels only.
  always_comb begin
    scl_rise_s = scl_filt_r & ~scl_prev_r;
    scl_fall_s = ~scl_filt_r & scl_prev_r;
    start_s    = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
    stop_s     = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;
    byte_in_s  = {shreg_r[6:0], sda_filt_r};
  end

  // Register file read mux at the current pointer.
  always_comb begin
    case (ptr_r)
      3'd0:    rd_byte_s = rw_q[0];
      3'd1:    rd_byte_s = rw_q[1];
      3'd2:    rd_byte_s = rw_q[2];
      3'd3:    rd_byte_s = rw_q[3];
      3'd4:    rd_byte_s = ro_reg4;
      3'd5:    rd_byte_s = ro_reg5;
      3'd6:    rd_byte_s = ro_reg6;
      3'd7:    rd_byte_s = ro_reg7;
      default: rd_byte_s = 8'h00;
    endcase
  end

  // Protocol FSM, register file writes and all registered outputs.
  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shreg_r   <= 8'h00;
      ack_r     <= 1'b0;
      rw_r      <= 1'b0;
      ptr_r     <= 3'd0;
      sda_oen_r <= 1'b1;
      for (int i = 0; i < 4; i++) rw_q[i] <= 8'h00;
      wr_stb_r  <= 1'b0;
      wr_idx_r  <= 2'd0;
      busy_r    <= 1'b0;
    end else begin
      wr_stb_r <= 1'b0;
      if (!slot_en || stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        sda_oen_r <= 1'b1;
        busy_r    <= 1'b0;
      end else if (start_s) begin
        // busy is kept across a repeated START until the address is judged
        state_r   <= ST_ADDR;
        bit_cnt_r <= 4'd0;
        sda_oen_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            bit_cnt_r <= 4'd0;
          end
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise_s) begin
              if (bit_cnt_r < 4'd8) begin
                shreg_r   <= byte_in_s;
                bit_cnt_r <= bit_cnt_r + 4'd1;
                if (bit_cnt_r == 4'd7) begin
                  case (state_r)
                    ST_ADDR: begin
                      if (byte_in_s[7:1] == slave_addr) begin
                        rw_r   <= byte_in_s[0];
                        busy_r <= 1'b1;
                        ack_r  <= 1'b1;
                      end else begin
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= 4'd0;
                        busy_r    <= 1'b0;
                        ack_r     <= 1'b0;
                      end
                    end
                    ST_PTR: begin
                      ptr_r <= byte_in_s[2:0];
                      ack_r <= 1'b1;
                    end
                    ST_WDATA: begin
                      if (!ptr_r[2]) begin
                        rw_q[ptr_r[1:0]] <= byte_in_s;
                        wr_stb_r         <= 1'b1;
                        wr_idx_r         <= ptr_r[1:0];
                        ack_r            <= 1'b1;
                      end else begin
                        ack_r <= RO_WRITE_ACK;
                      end
                    end
                    default: ack_r <= 1'b0;
                  endcase
                end
              end else begin
                bit_cnt_r <= 4'd9;
              end
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oen_r <= ~ack_r;
              end else if (bit_cnt_r == 4'd9) begin
                sda_oen_r <= 1'b1;
                bit_cnt_r <= 4'd0;
                case (state_r)
                  ST_ADDR: begin
                    if (rw_r) begin
                      // read data is captured here so later ro_reg changes cannot tear it
                      state_r   <= ST_RDATA;
                      shreg_r   <= {rd_byte_s[6:0], 1'b0};
                      sda_oen_r <= rd_byte_s[7];
                    end else begin
                      state_r <= ST_PTR;
                    end
                  end
                  ST_PTR: state_r <= ST_WDATA;
                  ST_WDATA: begin
                    if (ack_r) begin
                      ptr_r <= ptr_r + 3'd1;
                    end else begin
                      state_r <= ST_IDLE;
                      busy_r  <= 1'b0;
                    end
                  end
                  default: state_r <= ST_IDLE;
                endcase
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise_s) begin
              if (bit_cnt_r < 4'd8) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end else if (bit_cnt_r == 4'd8) begin
                if (sda_filt_r) begin
                  state_r   <= ST_IDLE;
                  bit_cnt_r <= 4'd0;
                  sda_oen_r <= 1'b1;
                  busy_r    <= 1'b0;
                end else begin
                  ptr_r     <= ptr_r + 3'd1;
                  bit_cnt_r <= 4'd9;
                end
              end
            end else if (scl_fall_s) begin
              if ((bit_cnt_r >= 4'd1) && (bit_cnt_r <= 4'd7)) begin
                sda_oen_r <= shreg_r[7];
                shreg_r   <= {shreg_r[6:0], 1'b0};
              end else if (bit_cnt_r == 4'd8) begin
                sda_oen_r <= 1'b1;
              end else if (bit_cnt_r == 4'd9) begin
                shreg_r   <= {rd_byte_s[6:0], 1'b0};
                sda_oen_r <= rd_byte_s[7];
                bit_cnt_r <= 4'd0;
              end
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            sda_oen_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_o   = 1'b0;
  assign sda_oen = sda_oen_r;
  assign rw_reg0 = rw_q[0];
  assign rw_reg1 = rw_q[1];
  assign rw_reg2 = rw_q[2];
  assign rw_reg3 = rw_q[3];
  assign wr_stb  = wr_stb_r;
  assign wr_idx  = wr_idx_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile
//   Directed bench: a bit-banged I2C master drives the pads (SDA is a
//   wired-AND of master and target), and each observation is checked with an
//   immediate assertion against hand-computed values.
module tb_i2c_target_regfile;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       arst_i, slot_en;
  logic [6:0] slave_addr;
  logic       scl_m, sda_m, sda_line;
  logic       sda_o, sda_oen;
  logic [7:0] ro_reg4, ro_reg5, ro_reg6, ro_reg7;
  logic [7:0] rw_reg0, rw_reg1, rw_reg2, rw_reg3;
  logic       wr_stb, busy;
  logic [1:0] wr_idx;

  int n_checks = 0;
  int n_fail   = 0;

  int         stb_cnt = 0;
  logic [1:0] stb_log [16];
  logic       mon_en = 1'b0;
  int         oen_low = 0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & sda_oen;

  i2c_target_regfile dut (
    .clk(clk), .arst_i(arst_i), .slot_en(slot_en), .slave_addr(slave_addr),
    .scl_i(scl_m), .sda_i(sda_line), .sda_o(sda_o), .sda_oen(sda_oen),
    .ro_reg4(ro_reg4), .ro_reg5(ro_reg5), .ro_reg6(ro_reg6), .ro_reg7(ro_reg7),
    .rw_reg0(rw_reg0), .rw_reg1(rw_reg1), .rw_reg2(rw_reg2), .rw_reg3(rw_reg3),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  // Log write strobes and watch for any target pull-down in monitored windows.
  always @(negedge clk) begin
    if (wr_stb) begin
      if (stb_cnt < 16) stb_log[stb_cnt] = wr_idx;
      stb_cnt++;
    end
    if (mon_en && !sda_oen) oen_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic clk_bit(input logic b, output logic smp);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    smp = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(mack, s);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;
    logic [7:0] ptr5;

    arst_i = 1'b0; slot_en = 1'b1; slave_addr = 7'h10;
    scl_m = 1'b1; sda_m = 1'b1;
    ro_reg4 = 8'h12; ro_reg5 = 8'h34; ro_reg6 = 8'h56; ro_reg7 = 8'h78;
    tick(3);
    check("rst_sda_oen", 32'(sda_oen), 32'h1);
    check("rst_sda_o",   32'(sda_o),   32'h0);
    check("rst_rw_regs", {rw_reg3, rw_reg2, rw_reg1, rw_reg0}, 32'h0);
    check("rst_wr_stb",  32'(wr_stb),  32'h0);
    check("rst_wr_idx",  32'(wr_idx),  32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    arst_i = 1'b1;
    tick(10);

    // Write A5 to reg1 and 5A to reg2
    bus_start();
    write_byte(8'h20, ack); check("wr_addr_ack", 32'(ack), 32'h0);
    check("wr_busy", 32'(busy), 32'h1);
    write_byte(8'h01, ack); check("wr_ptr_ack", 32'(ack), 32'h0);
    write_byte(8'hA5, ack); check("wr_d0_ack", 32'(ack), 32'h0);
    write_byte(8'h5A, ack); check("wr_d1_ack", 32'(ack), 32'h0);
    bus_stop(); tick(10);
    check("wr_busy_after_stop", 32'(busy), 32'h0);
    check("wr_rw_regs", {rw_reg3, rw_reg2, rw_reg1, rw_reg0}, 32'h005AA500);
    check("wr_stb_cnt", 32'(stb_cnt), 32'd2);
    check("wr_idx_first",  32'(stb_log[0]), 32'd1);
    check("wr_idx_second", 32'(stb_log[1]), 32'd2);

    // Read ro_reg4..7 through a repeated START
    bus_start();
    write_byte(8'h20, ack); check("rd_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h04, ack); check("rd_ptr_ack",  32'(ack), 32'h0);
    bus_start();
    write_byte(8'h21, ack); check("rd_addr_r_ack", 32'(ack), 32'h0);
    read_byte(1'b0, d); check("rd_b0", 32'(d), 32'h12);
    read_byte(1'b0, d); check("rd_b1", 32'(d), 32'h34);
    read_byte(1'b0, d); check("rd_b2", 32'(d), 32'h56);
    read_byte(1'b1, d); check("rd_b3", 32'(d), 32'h78);
    check("rd_busy_after_nack", 32'(busy), 32'h0);
    bus_stop(); tick(10);

    // Pointer wrap: reg7 then reg0
    bus_start();
    write_byte(8'h20, ack); write_byte(8'h00, ack);
    write_byte(8'hC3, ack); check("wrap_wr_ack", 32'(ack), 32'h0);
    bus_stop(); tick(10);
    check("wrap_rw0", 32'(rw_reg0), 32'hC3);
    check("wrap_stb_idx", 32'(stb_log[2]), 32'd0);
    bus_start();
    write_byte(8'h20, ack); write_byte(8'h07, ack);
    bus_start();
    write_byte(8'h21, ack); check("wrap_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, d); check("wrap_b7", 32'(d), 32'h78);
    read_byte(1'b1, d); check("wrap_b0", 32'(d), 32'hC3);
    bus_stop(); tick(10);

    // Wrong address: no ACK, SDA never pulled, nothing written
    oen_low = 0; mon_en = 1'b1;
    bus_start();
    write_byte(8'h40, ack); check("bad_addr_nack", 32'(ack), 32'h1);
    check("bad_busy", 32'(busy), 32'h0);
    write_byte(8'h00, ack); check("bad_d0_nack", 32'(ack), 32'h1);
    write_byte(8'h11, ack); check("bad_d1_nack", 32'(ack), 32'h1);
    bus_stop(); tick(10);
    mon_en = 1'b0;
    check("bad_oen_low", 32'(oen_low), 32'd0);
    check("bad_rw_regs", {rw_reg3, rw_reg2, rw_reg1, rw_reg0}, 32'h005AA5C3);
    check("bad_stb_cnt", 32'(stb_cnt), 32'd3);

    // Slot gating mid-byte during a write to reg3
    bus_start();
    write_byte(8'h20, ack); write_byte(8'h03, ack);
    check("slot_ptr_ack", 32'(ack), 32'h0);
    clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
    check("slot_busy_before", 32'(busy), 32'h1);
    slot_en = 1'b0;
    tick(1);
    check("slot_oen_next", 32'(sda_oen), 32'h1);
    check("slot_busy_off", 32'(busy), 32'h0);
    oen_low = 0; mon_en = 1'b1;
    clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
    clk_bit(1'b1, ack); check("slot_no_ack", 32'(ack), 32'h1);
    bus_stop(); tick(10);
    mon_en = 1'b0;
    check("slot_oen_low", 32'(oen_low), 32'd0);
    check("slot_rw3_kept", 32'(rw_reg3), 32'h00);
    slot_en = 1'b1; tick(10);
    bus_start();
    write_byte(8'h20, ack); write_byte(8'h03, ack);
    write_byte(8'h3C, ack); check("slot_rewrite_ack", 32'(ack), 32'h0);
    bus_stop(); tick(10);
    check("slot_rw3_new", 32'(rw_reg3), 32'h3C);
    check("slot_stb_idx", 32'(stb_log[3]), 32'd3);

    // SCL glitch while shifting pointer 0x05, then write to read-only reg5
    bus_start();
    write_byte(8'h20, ack);
    ptr5 = 8'h05;
    for (int i = 7; i >= 5; i--) clk_bit(ptr5[i], s);
    scl_m = 1'b1; tick(2);
    scl_m = 1'b0; tick(Q);
    for (int i = 4; i >= 0; i--) clk_bit(ptr5[i], s);
    clk_bit(1'b1, ack); check("glitch_ptr_ack", 32'(ack), 32'h0);
    write_byte(8'h99, ack);
`ifdef I2C_TARGET_RO_NACK_EN
    check("ro_wr_ack", 32'(ack), 32'h1);
    check("ro_wr_busy", 32'(busy), 32'h0);
`else
    check("ro_wr_ack", 32'(ack), 32'h0);
    check("ro_wr_busy", 32'(busy), 32'h1);
`endif
    bus_start();
    write_byte(8'h21, ack); check("ro_rd_addr_ack", 32'(ack), 32'h0);
    ro_reg5 = 8'hEE; ro_reg6 = 8'hEE;  // byte already captured
    read_byte(1'b1, d);
`ifdef I2C_TARGET_RO_NACK_EN
    check("ro_rd_ptr5", 32'(d), 32'h34);
`else
    check("ro_rd_ptr6", 32'(d), 32'h56);
`endif
    bus_stop(); tick(10);
    check("ro_rw_regs", {rw_reg3, rw_reg2, rw_reg1, rw_reg0}, 32'h3C5AA5C3);
    check("ro_stb_cnt", 32'(stb_cnt), 32'd4);

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
